// File: rtl/alu_sequencer_if.sv
// Request, response and datapath signals of the ALU sequencer grouped as one bus.
// The master side is the control unit together with the ALU datapath.
// The slave side is the sequencer.
interface alu_sequencer_if;
  // Command request channel.
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [3:0] req_a;
  logic [3:0] req_b;
  // Shared ALU datapath, which responds combinationally.
  logic [2:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic       alu_cout;
  // Result response channel.
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_cout;
  logic       rsp_zero;

  modport master (
    output req_valid, req_cmd, req_a, req_b, rsp_ready, alu_res, alu_cout,
    input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_cout, rsp_zero
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, rsp_ready, alu_res, alu_cout,
    output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_cout, rsp_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU command sequencer. It accepts ADD/SUB/MUL/NEG commands and issues one micro-op
// per cycle to the shared 4-bit ALU datapath.
// Multi-pass commands keep their partial results in tmp/c1 (SUB) or acc (MUL).
// The final 8-bit result is returned on the response channel.
module alu_sequencer (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            abort,
  alu_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SUB = 2'b01;
  localparam logic [1:0] CMD_MUL = 2'b10;
  localparam logic [1:0] CMD_NEG = 2'b11;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_NEG  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;

  logic [1:0] state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [1:0] cmd_q, cmd_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] tmp_q, tmp_d;
  logic       c1_q, c1_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_cout_q, rsp_cout_d;

  logic [2:0] op_c;
  logic [3:0] a_c, b_c;
  logic       last_pass;
  logic [7:0] mul_acc;

  // Shift-add step: the carry and the sum enter at the top, and the multiplier shifts out at the bottom.
  assign mul_acc = {bus.alu_cout, bus.alu_res, acc_q[3:1]};

  // Decide whether the current EXEC cycle is the final pass of the latched command.
  always_comb begin
    last_pass = 1'b1;
    case (cmd_q)
      CMD_SUB: last_pass = (step_q == 2'd1);
      CMD_MUL: last_pass = (step_q == 2'd3);
      default: last_pass = 1'b1;
    endcase
  end

  // Drive the datapath micro-op for this cycle. The datapath is held at PASS 0/0 outside EXEC.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    op_c = OP_PASS;
    a_c  = 4'h0;
    b_c  = 4'h0;
    if (state_q == ST_EXEC) begin
      case (cmd_q)
        CMD_ADD: begin op_c = OP_ADD; a_c = op_a_q; b_c = op_b_q; end
        CMD_NEG: begin op_c = OP_NEG; a_c = op_a_q; end
        CMD_SUB: begin
          if (step_q == 2'd0) begin op_c = OP_NEG; a_c = op_b_q; end
          else begin op_c = OP_ADD; a_c = op_a_q; b_c = tmp_q; end
        end
        default: begin
          a_c = acc_q[7:4];
          if (acc_q[0]) begin op_c = OP_ADD; b_c = op_a_q; end
        end
      endcase
    end
  end

  // Next-state logic: accept in IDLE, capture each pass in EXEC, wait for the handshake in DONE.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cmd_d      = cmd_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    acc_d      = acc_q;
    tmp_d      = tmp_q;
    c1_d       = c1_q;
    rsp_data_d = rsp_data_q;
    rsp_cout_d = rsp_cout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && !abort) begin
          cmd_d   = bus.req_cmd;
          op_a_d  = bus.req_a;
          op_b_d  = bus.req_b;
          step_d  = 2'd0;
          acc_d   = {4'h0, bus.req_b};
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if (cmd_q == CMD_SUB && step_q == 2'd0) begin
            tmp_d = bus.alu_res;
            c1_d  = bus.alu_cout;
          end
          if (cmd_q == CMD_MUL) acc_d = mul_acc;
          if (last_pass) begin
            state_d = ST_DONE;
            case (cmd_q)
              CMD_MUL: begin rsp_data_d = mul_acc; rsp_cout_d = 1'b0; end
              CMD_SUB: begin rsp_data_d = {4'h0, bus.alu_res}; rsp_cout_d = c1_q | bus.alu_cout; end
              default: begin rsp_data_d = {4'h0, bus.alu_res}; rsp_cout_d = bus.alu_cout; end
            endcase
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        if (abort || bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers. An asynchronous reset clears everything to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      step_q     <= 2'd0;
      cmd_q      <= 2'd0;
      op_a_q     <= 4'h0;
      op_b_q     <= 4'h0;
      acc_q      <= 8'h00;
      tmp_q      <= 4'h0;
      c1_q       <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_cout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample its pre-edge value, so the order of these statements does not matter.
      state_q    <= state_d;
      step_q     <= step_d;
      cmd_q      <= cmd_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      acc_q      <= acc_d;
      tmp_q      <= tmp_d;
      c1_q       <= c1_d;
      rsp_data_q <= rsp_data_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_zero  = (rsp_data_q == 8'h00);
  assign bus.alu_op    = op_c;
  assign bus.alu_a     = a_c;
  assign bus.alu_b     = b_c;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Controller that accepts arithmetic commands over a valid/ready request channel and sequences the shared 4-bit ALU datapath (operand preprocess stage + 4-bit adder), one micro-op per cycle.
- Multi-pass commands (SUB, MUL) are built from the datapath primitives, with results captured into internal registers between passes.
- Returns an 8-bit result and flags on a valid/ready response channel.
- Sits between the control unit and the ALU datapath; it is the only driver of the datapath's Op/A/B inputs.

Parameters:
- None. Widths are fixed: 4-bit operands, 8-bit result.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous cancel of the in-flight command.
- req_valid  in  1  command valid.
- req_ready  out  1  sequencer can accept a command.
- req_cmd  in  2  command: 00 ADD, 01 SUB, 10 MUL, 11 NEG.
- req_a  in  4  operand A.
- req_b  in  4  operand B.
- alu_op  out  3  datapath Op: 000 PASS (0+A), 001 NEG (1+~A), 010 ADD (A+B), 011 INC (A+1).
- alu_a  out  4  datapath A.
- alu_b  out  4  datapath B.
- alu_res  in  4  datapath sum, combinational from alu_op/alu_a/alu_b in the same cycle.
- alu_cout  in  1  datapath carry out, same cycle.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  8  result.
- rsp_cout  out  1  carry / no-borrow flag.
- rsp_zero  out  1  rsp_data == 0.

Behaviour:
- **FSM states:** IDLE, EXEC, DONE. Registers:
  - step, 2-bit pass counter.
  - opA/opB, latched operands.
  - acc, 8-bit.
  - tmp, 4-bit.
  - c1, 1-bit.
- **Reset (async, reset_n=0):**
  - State IDLE, all registers 0.
  - Outputs: req_ready=1, rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_zero=1, alu_op=000, alu_a=0, alu_b=0.
  - No request is captured while reset_n=0.
  - Reset mid-command discards it; no response is produced.
- **IDLE:**
  - req_ready=1.
  - On req_valid & ~abort at the clock edge: latch cmd/A/B, step=0, go to EXEC.
- **EXEC:**
  - req_ready=0.
  - Each cycle drives one micro-op and captures alu_res/alu_cout at the edge.
- **Per-command micro-ops:**
  - **ADD** (1 pass): op 010, a=A, b=B. rsp_data={0000,res}, rsp_cout=cout.
  - **NEG** (1 pass): op 001, a=A. rsp_data={0000,res}, rsp_cout=cout (1 only when A=0).
  - **SUB** (2 passes):
    - Pass 0: op 001, a=B; tmp=res, c1=cout.
    - Pass 1: op 010, a=A, b=tmp.
    - rsp_data={0000,res}, rsp_cout=c1|cout, which equals 1 iff A>=B unsigned.
  - **MUL** (4 passes, unsigned shift-add):
    - acc initialised to {0000,B} at accept.
    - Each pass: if acc[0], drive op 010, a=acc[7:4], b=A; else drive op 000, a=acc[7:4], b=0.
    - Then acc={cout,res,acc[3:1]}.
    - After pass 3, rsp_data=acc=A*B, rsp_cout=0.
- **Leaving EXEC:** after the last pass, go to DONE with rsp_* registered.
- **Datapath idle value:** alu_op/alu_a/alu_b are 000/0/0 in IDLE and DONE.
- **DONE:**
  - rsp_valid=1.
  - rsp_data/rsp_cout/rsp_zero held stable until rsp_valid & rsp_ready, then go to IDLE.
  - rsp_valid deasserts the next cycle.
  - No new request is accepted until back in IDLE (one idle cycle between commands).
- **Latency:** accept edge N. rsp_valid first high after edge N+1 (ADD/NEG), N+2 (SUB), N+4 (MUL).
- **abort:**
  - In EXEC or DONE: go to IDLE at the next edge; result dropped, rsp_valid=0.
  - In IDLE together with req_valid: abort wins and no accept occurs.
  - abort and rsp_ready in the same DONE cycle: treated as abort, with the same end state.
- **Flag and width rules:**
  - rsp_zero is derived from the registered rsp_data.
  - All arithmetic is modulo 2^4 per pass; the carry is only as specified per command.
  - req_cmd/req_a/req_b are ignored outside the accept edge.

Test Plan:
- Bench connects a behavioural model of the ALU datapath per the alu_op table above.
- ADD A=9 B=8 → rsp_data=0x01, rsp_cout=1, rsp_zero=0; rsp_valid at N+1; alu_op=010 for exactly one cycle.
- SUB A=3 B=5 → 0x0E, rsp_cout=0. SUB A=7 B=0 → 0x07, rsp_cout=1. SUB A=5 B=5 → 0x00, rsp_zero=1, rsp_cout=1. Micro-op sequence 001 then 010 checked.
- MUL A=15 B=15 → 0xE1 at N+4. MUL A=0 B=9 → 0x00, rsp_zero=1. MUL A=6 B=10 → 0x3C; alu_op sequence 000,010,000,010.
- NEG A=0 → 0x00, cout=1, zero=1. NEG A=1 → 0x0F, cout=0.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE → rsp_* stable, req_ready=0, and a pending req_valid is not accepted until one cycle after the rsp handshake.
- Abort in MUL pass 2 → IDLE next cycle, no rsp_valid, following ADD 1+1 returns 0x02. Then reset_n pulsed low mid-SUB (asynchronous, off-edge) → outputs immediately at reset values, no response.
